// File: rtl/ripple_sampler_pkg.sv
// Shared defaults for the ripple-counter sampler and a helper for the
// stability counter width.
package ripple_sampler_pkg;

  localparam int WIDTH_DEF         = 4;
  localparam int SYNC_STAGES_DEF   = 2;
  localparam int STABLE_CYCLES_DEF = 2;
  localparam int WRAP_W_DEF        = 8;

  // Bits needed to hold 0..n inclusive.
  function automatic int stab_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ripple_down_sampler_sync_bus.sv
// WIDTH-bit multi-flop synchronizer with asynchronous active-high reset.
module sync_bus #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/ripple_down_sampler.sv
// Samples an asynchronous ripple down-counter, publishes each settled count
// over valid/ready and flags underflow wraps. Optional tally: RIPPLE_SAMPLER_WRAP_CNT_EN.
module ripple_down_sampler
  import ripple_sampler_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int WRAP_W        = WRAP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  cnt_async,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              overrun
);

  // Handshake: a transfer happens on any rising edge where out_valid and
  // out_ready are both high; out_data holds still while waiting unless a
  // newer settled count overwrites it (which sets the sticky overrun).

  localparam int                STAB_W   = stab_width(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_SAT = STAB_W'(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_PRE = STAB_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0]  sync_q;
  logic [WIDTH-1:0]  sync_prev_q;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [WIDTH-1:0]  last_acc_q, last_acc_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              wrap_pulse_q, wrap_pulse_d;
  logic              overrun_q, overrun_d;
  logic              same, accept, wrap_hit, xfer;

  sync_bus #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (cnt_async),
    .q_o   (sync_q)
  );

  always_comb begin
    stab_d       = stab_q;
    last_acc_d   = last_acc_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    overrun_d    = overrun_q;
    same         = (sync_q == sync_prev_q);
    xfer         = out_valid_q && out_ready;

    if (!same)                  stab_d = '0;
    else if (stab_q != STAB_SAT) stab_d = stab_q + 1'b1;

    // Accept only on the cycle stab first reaches saturation.
    accept       = same && (stab_q == STAB_PRE) && (sync_q != last_acc_q);
    wrap_hit     = accept && (sync_q > last_acc_q);
    wrap_pulse_d = wrap_hit;

    if (accept) begin
      last_acc_d  = sync_q;
      out_data_d  = sync_q;
      out_valid_d = 1'b1;
      if (out_valid_q && !xfer) overrun_d = 1'b1;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_prev_q  <= '0;
      stab_q       <= '0;
      last_acc_q   <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync_prev_q  <= sync_q;
      stab_q       <= stab_d;
      last_acc_q   <= last_acc_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      wrap_pulse_q <= wrap_pulse_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef RIPPLE_SAMPLER_WRAP_CNT_EN
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (wrap_hit && (wrap_cnt_q != {WRAP_W{1'b1}})) wrap_cnt_d = wrap_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wrap_cnt_q <= '0;
    else       wrap_cnt_q <= wrap_cnt_d;
  end

  assign wrap_count = wrap_cnt_q;
`else
  assign wrap_count = '0;
`endif

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign wrap_pulse = wrap_pulse_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/ripple_down_sampler.md
# ripple_down_sampler

- Brings the asynchronous output of the 4-bit ripple-down T-flip-flop counter into the system clock domain. That counter's bits toggle on each other's falling edges, so its value is glitchy and skewed.
- Synchronizes the count, filters out intermediate ripple states, and publishes each settled count over a valid/ready handshake.
- Flags every underflow wrap of the counter (0 → 2^WIDTH−1) and tallies them.
- Sits directly downstream of the ripple counter.

## Interface
- WIDTH, 4, counter width.
- SYNC_STAGES, 2, synchronizer depth (≥2).
- STABLE_CYCLES, 2, consecutive identical synced samples required to accept a value (≥1).
- WRAP_W, 8, width of the wrap tally.
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- cnt_async  in  WIDTH  raw ripple counter bits (Q outputs).
- out_ready  in  1  consumer accepts out_data this cycle.
- out_valid  out  1  out_data holds an unconsumed settled count.
- out_data  out  WIDTH  last published settled count.
- wrap_pulse  out  1  one-cycle strobe on an accepted wrap.
- wrap_count  out  WRAP_W  saturating wrap tally.
- overrun  out  1  sticky: a published value was overwritten before being consumed.

## Operation
- **Sync:** each cnt_async bit passes through SYNC_STAGES flops. The last stage is sync_q; its previous-cycle copy is sync_prev.
- **Stability counter `stab`:**
  - Cleared to 0 when sync_q ≠ sync_prev.
  - Otherwise increments, saturating at STABLE_CYCLES.
- **Accept:** fires when stab reaches STABLE_CYCLES in this cycle (transition only, not while saturated) and sync_q ≠ last_acc.
  - On accept, last_acc ← sync_q.
  - A value that settles back to last_acc is not republished.
- **Wrap:** on accept, if sync_q > last_acc (unsigned), wrap_pulse = 1 for that cycle and wrap_count increments, saturating at 2^WRAP_W−1.
  - Each single down-step from 0 to 2^WIDTH−1 is one wrap.
  - Multi-step jumps are judged by the same magnitude rule.
- **Output register (handshake):**
  - Transfer occurs when out_valid && out_ready.
  - Accept with out_valid = 0, or with a transfer in the same cycle: load out_data, out_valid = 1, no overrun.
  - Accept with out_valid = 1 and no transfer: overwrite out_data, keep out_valid, set overrun.
  - Transfer with no accept: out_valid ← 0.
  - out_data is stable while out_valid && !out_ready, except on an overwrite.
- **Reset values:**
  - Sync flops, sync_prev, last_acc, out_data: 0.
  - stab: 0.
  - out_valid, wrap_pulse, overrun: 0.
  - wrap_count: 0.
  - Reset mid-operation discards any pending value; overrun is cleared only by reset.
- The block assumes the ripple counter is held at 0 by the same reset.

## Timing
- A clean change on cnt_async, first sampled at edge k, drives out_valid high after edge k+SYNC_STAGES+STABLE_CYCLES (edge k+4 at defaults). wrap_pulse and the wrap_count update occur on that same edge.
- Toggling faster than STABLE_CYCLES clk periods is never published.
- out_valid drops on the edge after a transfer (the transfer edge itself).
- Fully synchronous outputs; no combinational path from input to output.

## Configuration
- RIPPLE_SAMPLER_WRAP_CNT_EN defined: wrap tally register present, as above.
- Not defined: wrap_count tied to 0, no tally flops. wrap_pulse and all other behaviour unchanged.

## Structure
- Shared package ripple_sampler_pkg: default parameter constants (WIDTH, SYNC_STAGES, STABLE_CYCLES, WRAP_W).
- Natural sub-module: sync_bus, a WIDTH-bit × SYNC_STAGES flop synchronizer with async active-high reset, instanced once.
- Stability filter, accept/wrap logic and output register stay in the top.

## Test plan
- **Reset, cnt_async = 0 held 20 cycles:** out_valid = 0, wrap_pulse never asserts, wrap_count = 0, overrun = 0.
- **Clean down-steps 0 → 15 → 14, each held 10 cycles, out_ready = 1:**
  - out_data = 15 at edge 4 after the step; wrap_pulse high exactly one cycle; wrap_count = 1.
  - Then out_data = 14, no wrap.
- **Ripple glitch 8 → 0 (1 cycle) → 7:** only 7 published; no wrap; 0 never appears.
- **out_ready = 0, steps 5 → 4 → 3:** out_valid stays high, out_data = 3, overrun = 1. Raising out_ready gives one transfer, then out_valid = 0.
- **17 full down-cycles with WRAP_W = 4:** wrap_count saturates at 15.
- **Reset asserted mid-settle:** all outputs return to 0 asynchronously; no publish after release until a new stable change occurs.
